// File: rtl/secded_72_64_pkg.sv
// Shared constants, H-matrix and pure encode/decode functions for the
// 72/64 Hsiao SECDED codec.
package secded_72_64_pkg;

    localparam int K = 64;
    localparam int R = 8;
    localparam int N = 72;

    // Data columns: the 56 weight-3 bytes ascending, then the first eight weight-5 bytes.
    localparam logic [R-1:0] H_COL [0:K-1] = '{
        8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13, 8'h15, 8'h16, 8'h19,
        8'h1A, 8'h1C, 8'h23, 8'h25, 8'h26, 8'h29, 8'h2A, 8'h2C,
        8'h31, 8'h32, 8'h34, 8'h38, 8'h43, 8'h45, 8'h46, 8'h49,
        8'h4A, 8'h4C, 8'h51, 8'h52, 8'h54, 8'h58, 8'h61, 8'h62,
        8'h64, 8'h68, 8'h70, 8'h83, 8'h85, 8'h86, 8'h89, 8'h8A,
        8'h8C, 8'h91, 8'h92, 8'h94, 8'h98, 8'hA1, 8'hA2, 8'hA4,
        8'hA8, 8'hB0, 8'hC1, 8'hC2, 8'hC4, 8'hC8, 8'hD0, 8'hE0,
        8'h1F, 8'h2F, 8'h37, 8'h3B, 8'h3D, 8'h3E, 8'h4F, 8'h57
    };

    typedef struct packed {
        logic [K-1:0] data;
        logic [R-1:0] syndrome;
        logic [1:0]   err;
    } dec_result_t;

    function automatic logic [R-1:0] calc_check(input logic [K-1:0] data);
        logic [R-1:0] chk;
        chk = '0;
        for (int i = 0; i < K; i++) begin
            if (data[i]) begin
                chk = chk ^ H_COL[i];
            end
        end
        return chk;
    endfunction

    function automatic dec_result_t decode_word(input logic [N-1:0] cw);
        dec_result_t res;
        logic [R-1:0] s;
        s = cw[N-1:K];
        for (int i = 0; i < K; i++) begin
            if (cw[i]) begin
                s = s ^ H_COL[i];
            end
        end
        // A syndrome that matches no data column (check-bit error, or >=3 bits) flips nothing.
        for (int i = 0; i < K; i++) begin
            res.data[i] = cw[i] ^ (s == H_COL[i]);
        end
        res.syndrome = s;
        res.err[0]   = ^s;
        res.err[1]   = (s != '0) && !(^s);
        return res;
    endfunction

endpackage

// File: rtl/secded_72_64_core.sv
// Combinational encode and syndrome/correct logic; no state.
module secded_72_64_core
    import secded_72_64_pkg::*;
(
    input  logic [K-1:0] enc_data_i,
    output logic [N-1:0] enc_cw_o,
    input  logic [N-1:0] dec_cw_i,
    output logic [K-1:0] dec_data_o,
    output logic [R-1:0] dec_syndrome_o,
    output logic [1:0]   dec_err_o
);

    dec_result_t dec_res;

    assign enc_cw_o = {calc_check(enc_data_i), enc_data_i};

    assign dec_res        = decode_word(dec_cw_i);
    assign dec_data_o     = dec_res.data;
    assign dec_syndrome_o = dec_res.syndrome;
    assign dec_err_o      = dec_res.err;

endmodule

// File: rtl/secded_72_64_codec.sv
// Registered SECDED 72/64 codec: independent 1-cycle encode and decode pipelines.
module secded_72_64_codec
    import secded_72_64_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enc_valid_i,
    input  logic [K-1:0] enc_data_i,
    output logic         enc_valid_o,
    output logic [N-1:0] enc_data_o,
    input  logic         dec_valid_i,
    input  logic [N-1:0] dec_data_i,
    output logic         dec_valid_o,
    output logic [K-1:0] dec_data_o,
    output logic [R-1:0] dec_syndrome_o,
    output logic [1:0]   dec_err_o
);

    logic [N-1:0] enc_cw;
    logic [K-1:0] dec_data;
    logic [R-1:0] dec_syndrome;
    logic [1:0]   dec_err;

    logic         enc_valid_d, enc_valid_q;
    logic [N-1:0] enc_data_d, enc_data_q;
    logic         dec_valid_d, dec_valid_q;
    logic [K-1:0] dec_data_d, dec_data_q;
    logic [R-1:0] dec_syndrome_d, dec_syndrome_q;
    logic [1:0]   dec_err_d, dec_err_q;

    secded_72_64_core u_core (
        .enc_data_i     (enc_data_i),
        .enc_cw_o       (enc_cw),
        .dec_cw_i       (dec_data_i),
        .dec_data_o     (dec_data),
        .dec_syndrome_o (dec_syndrome),
        .dec_err_o      (dec_err)
    );

    // Result registers only load on valid so downstream can keep sampling after valid drops.
    always_comb begin
        enc_valid_d    = enc_valid_i;
        enc_data_d     = enc_data_q;
        dec_valid_d    = dec_valid_i;
        dec_data_d     = dec_data_q;
        dec_syndrome_d = dec_syndrome_q;
        dec_err_d      = dec_err_q;
        if (enc_valid_i) begin
            enc_data_d = enc_cw;
        end
        if (dec_valid_i) begin
            dec_data_d     = dec_data;
            dec_syndrome_d = dec_syndrome;
            dec_err_d      = dec_err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enc_valid_q    <= 1'b0;
            enc_data_q     <= '0;
            dec_valid_q    <= 1'b0;
            dec_data_q     <= '0;
            dec_syndrome_q <= '0;
            dec_err_q      <= '0;
        end else begin
            enc_valid_q    <= enc_valid_d;
            enc_data_q     <= enc_data_d;
            dec_valid_q    <= dec_valid_d;
            dec_data_q     <= dec_data_d;
            dec_syndrome_q <= dec_syndrome_d;
            dec_err_q      <= dec_err_d;
        end
    end

    assign enc_valid_o    = enc_valid_q;
    assign enc_data_o     = enc_data_q;
    assign dec_valid_o    = dec_valid_q;
    assign dec_data_o     = dec_data_q;
    assign dec_syndrome_o = dec_syndrome_q;
    assign dec_err_o      = dec_err_q;

endmodule

// File: tb/tb_secded_72_64_codec.sv
// Directed and small randomised self-checking bench for secded_72_64_codec.
module tb_secded_72_64_codec;

    logic        clk_i;
    logic        rst_i;
    logic        enc_valid_i;
    logic [63:0] enc_data_i;
    logic        enc_valid_o;
    logic [71:0] enc_data_o;
    logic        dec_valid_i;
    logic [71:0] dec_data_i;
    logic        dec_valid_o;
    logic [63:0] dec_data_o;
    logic [7:0]  dec_syndrome_o;
    logic [1:0]  dec_err_o;

    int n_checks;
    int n_errors;
    logic [7:0] tb_h [0:63];

    secded_72_64_codec dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enc_valid_i    (enc_valid_i),
        .enc_data_i     (enc_data_i),
        .enc_valid_o    (enc_valid_o),
        .enc_data_o     (enc_data_o),
        .dec_valid_i    (dec_valid_i),
        .dec_data_i     (dec_data_i),
        .dec_valid_o    (dec_valid_o),
        .dec_data_o     (dec_data_o),
        .dec_syndrome_o (dec_syndrome_o),
        .dec_err_o      (dec_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent column table: enumerate weight-3 bytes ascending, then weight-5 bytes.
    task automatic build_h();
        int n3;
        int n5;
        n3 = 0;
        n5 = 0;
        for (int v = 0; v < 256; v++) begin
            if ($countones(v[7:0]) == 3 && n3 < 56) begin
                tb_h[n3] = v[7:0];
                n3++;
            end
        end
        for (int v = 0; v < 256; v++) begin
            if ($countones(v[7:0]) == 5 && n5 < 8) begin
                tb_h[56 + n5] = v[7:0];
                n5++;
            end
        end
    endtask

    function automatic logic [71:0] model_enc(input logic [63:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 64; i++) begin
            if (d[i]) c = c ^ tb_h[i];
        end
        return {c, d};
    endfunction

    function automatic logic [7:0] model_col(input int b);
        logic [7:0] one;
        one = 8'h01;
        if (b < 64) return tb_h[b];
        return one << (b - 64);
    endfunction

    task automatic drive(input logic ev, input logic [63:0] ed, input logic dv, input logic [71:0] dd);
        @(negedge clk_i);
        enc_valid_i = ev;
        enc_data_i  = ed;
        dec_valid_i = dv;
        dec_data_i  = dd;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".enc_valid"}, 72'(enc_valid_o), 72'd0);
        check({tag, ".enc_data"},  enc_data_o, 72'd0);
        check({tag, ".dec_valid"}, 72'(dec_valid_o), 72'd0);
        check({tag, ".dec_data"},  72'(dec_data_o), 72'd0);
        check({tag, ".dec_syn"},   72'(dec_syndrome_o), 72'd0);
        check({tag, ".dec_err"},   72'(dec_err_o), 72'd0);
    endtask

    task automatic check_dec(input string tag, input logic [63:0] d, input logic [7:0] s, input logic [1:0] e);
        check({tag, ".valid"}, 72'(dec_valid_o), 72'd1);
        check({tag, ".data"},  72'(dec_data_o), 72'(d));
        check({tag, ".syn"},   72'(dec_syndrome_o), 72'(s));
        check({tag, ".err"},   72'(dec_err_o), 72'(e));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] d;
        logic [71:0] cw;
        logic [71:0] flip;
        logic [71:0] last_cw;
        logic [63:0] last_d;
        int b1;
        int b2;

        n_checks    = 0;
        n_errors    = 0;
        rst_i       = 1'b1;
        enc_valid_i = 1'b0;
        enc_data_i  = '0;
        dec_valid_i = 1'b0;
        dec_data_i  = '0;
        build_h();

        // Reset held with valid requests: they must be dropped.
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 72'hFF_FFFF_FFFF_FFFF_FFFF);
            $display("reset cycle %0d", k);
            check_all_zero("reset");
        end
        rst_i = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 72'h0);
        check("idle.enc_valid", 72'(enc_valid_o), 72'd0);

        // First valid after reset; decode side carries bit 5 flipped.
        drive(1'b1, 64'h1, 1'b1, 72'h07_0000000000000021);
        $display("first enc d=1 cw=%h dec syn=%h err=%b", enc_data_o, dec_syndrome_o, dec_err_o);
        check("first.enc_valid", 72'(enc_valid_o), 72'd1);
        check("first.enc_data", enc_data_o, 72'h07_0000000000000001);
        check_dec("first.dec", 64'h1, 8'h15, 2'b01);

        // Directed encodes and hand-computed decodes.
        drive(1'b1, 64'h0, 1'b1, 72'h00_0000000000000001);
        $display("enc d=0 cw=%h | dec bit0 syn=%h err=%b", enc_data_o, dec_syndrome_o, dec_err_o);
        check("enc0", enc_data_o, 72'h00_0000000000000000);
        check_dec("sbe_bit0", 64'h0, 8'h07, 2'b01);

        drive(1'b1, 64'h8000_0000_0000_0000, 1'b1, 72'h01_0000000000000000);
        $display("enc d=1<<63 cw=%h | dec bit64 syn=%h err=%b", enc_data_o, dec_syndrome_o, dec_err_o);
        check("enc63", enc_data_o, 72'h57_8000000000000000);
        check_dec("sbe_bit64", 64'h0, 8'h01, 2'b01);

        drive(1'b0, 64'h0, 1'b1, 72'h00_0000000000000003);
        $display("dec bits0,1 syn=%h err=%b", dec_syndrome_o, dec_err_o);
        check("dbe01.syn", 72'(dec_syndrome_o), 72'h0C);
        check("dbe01.err", 72'(dec_err_o), 72'd2);

        // Random clean round trips: encode, then feed the codeword back to decode.
        for (int t = 0; t < 48; t++) begin
            d = {$urandom, $urandom};
            drive(1'b1, d, 1'b0, 72'h0);
            cw = enc_data_o;
            check("rt.enc", cw, model_enc(d));
            drive(1'b0, 64'h0, 1'b1, cw);
            $display("roundtrip d=%h cw=%h out=%h err=%b", d, cw, dec_data_o, dec_err_o);
            check_dec("rt.dec", d, 8'h00, 2'b00);
        end

        // Random single-bit errors.
        for (int t = 0; t < 48; t++) begin
            d  = {$urandom, $urandom};
            b1 = $urandom_range(0, 71);
            flip = 72'd1 << b1;
            drive(1'b0, 64'h0, 1'b1, model_enc(d) ^ flip);
            $display("sbe d=%h bit=%0d syn=%h err=%b", d, b1, dec_syndrome_o, dec_err_o);
            check_dec("sbe.rand", d, model_col(b1), 2'b01);
        end

        // Random distinct double-bit errors.
        for (int t = 0; t < 48; t++) begin
            d  = {$urandom, $urandom};
            b1 = $urandom_range(0, 71);
            b2 = (b1 + 1 + $urandom_range(0, 70)) % 72;
            flip = (72'd1 << b1) | (72'd1 << b2);
            drive(1'b0, 64'h0, 1'b1, model_enc(d) ^ flip);
            $display("dbe d=%h bits=%0d,%0d syn=%h err=%b", d, b1, b2, dec_syndrome_o, dec_err_o);
            check("dbe.valid", 72'(dec_valid_o), 72'd1);
            check("dbe.syn", 72'(dec_syndrome_o), 72'(model_col(b1) ^ model_col(b2)));
            check("dbe.err", 72'(dec_err_o), 72'd2);
        end

        // Back-to-back on both paths, one result per cycle.
        for (int k = 0; k < 8; k++) begin
            d = 64'h1111_1111_1111_1111 * 64'(k + 1);
            drive(1'b1, d, 1'b1, model_enc(d) ^ (72'd1 << (k * 9)));
            $display("stream k=%0d enc=%h dec=%h err=%b", k, enc_data_o, dec_data_o, dec_err_o);
            check("stream.enc_valid", 72'(enc_valid_o), 72'd1);
            check("stream.enc_data", enc_data_o, model_enc(d));
            check_dec("stream.dec", d, model_col(k * 9), 2'b01);
        end
        last_d  = d;
        last_cw = model_enc(d);

        // Gap: outputs hold, valids drop.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 64'hDEAD_BEEF_0000_0001, 1'b0, 72'hAB_CDEF_0123_4567_89AB);
            $display("gap k=%0d enc_v=%b dec_v=%b", k, enc_valid_o, dec_valid_o);
            check("gap.enc_valid", 72'(enc_valid_o), 72'd0);
            check("gap.enc_data", enc_data_o, last_cw);
            check("gap.dec_valid", 72'(dec_valid_o), 72'd0);
            check("gap.dec_data", 72'(dec_data_o), 72'(last_d));
            check("gap.dec_syn", 72'(dec_syndrome_o), 72'(model_col(63)));
            check("gap.dec_err", 72'(dec_err_o), 72'd1);
        end

        // Mid-stream reset wins over a simultaneous valid.
        drive(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 72'h00_0000000000000003);
        check("pre_rst.enc_valid", 72'(enc_valid_o), 72'd1);
        rst_i = 1'b1;
        drive(1'b1, 64'h0FED_CBA9_8765_4321, 1'b1, 72'h00_0000000000000003);
        $display("mid-stream reset enc_v=%b dec_v=%b", enc_valid_o, dec_valid_o);
        check_all_zero("midrst");
        rst_i = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 72'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
